ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
Control-path pipeline slice of the 5-stage MIPS core. It takes the main decoder's ID-stage control bits and ALU-op class, decodes the 4-bit ALU control from funct, and carries all control through the ID/EX, EX/MEM and MEM/WB registers. It also forms the ID-stage branch-taken select. It sits between the main decoder and the datapath.

Parameters:
None. All widths are fixed; the internal register sub-module takes WIDTH, default 1, meaning the register width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low (0 = reset); one clock domain
functD  in  6  instruction funct field (ID)
aluopD  in  2  ALU-op class from main decoder
memtoregD, memwriteD, alusrcD, regwriteD, jalD, lbD, sbD, multordivD, hlwriteD  in  1 each  ID control bits
regdstD  in  2  destination select
mfhlD  in  2  move-from-HI/LO select
branchD, bneD, equalD  in  1 each  beq flag, bne flag, register-compare result
flushE  in  1  synchronous clear of ID/EX
pcsrcD  out  1  branch taken
alucontrolE  out  4  ALU control (EX)
memtoregE, alusrcE, regwriteE, multordivE, hlwriteE  out  1 each  EX control
regdstE  out  2  EX destination select
memtoregM, memwriteM, regwriteM, hlwriteM, sbM  out  1 each  MEM control
memtoregW, regwriteW, jalW, lbW, hlwriteW  out  1 each  WB control
mfhlW  out  2  WB HI/LO select

Behaviour:
- pcsrcD = (branchD & equalD) | (bneD & ~equalD). It is purely combinational.
- ALU decode (combinational):
  - aluopD 00 -> 0010 (ADD)
  - aluopD 01 -> 0110 (SUB)
  - aluopD 11 -> 0001 (OR)
  - aluopD 10 -> decode by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000 (AND), 100101 -> 0001, 101010 -> 0111 (SLT), 011000 -> 1000 (MULT), 011010 -> 1001 (DIV), 010000/010010 (mfhi/mflo) -> 0010.
  - Any other funct -> 0010. The output is never X.
- ID/EX register: 17 bits, packed MSB to LSB as {memtoreg, memwrite, alusrc, regdst[1:0], regwrite, alucontrol[3:0], jal, lb, multordiv, hlwrite, mfhl[1:0], sb}.
  - On each rising edge the E copy takes the D value.
  - If flushE=1 at the edge, all 17 bits load 0.
- EX/MEM register: 9 bits, {memtoreg, memwrite, regwrite, jal, lb, hlwrite, mfhl[1:0], sb}. Loaded every edge; no flush and no stall.
- MEM/WB register: 7 bits, {memtoreg, regwrite, jal, lb, hlwrite, mfhl[1:0]}. Loaded every edge.
- Latency: a D-stage value appears at the E outputs 1 edge later, at M after 2 edges and at W after 3 edges.
- Reset: reset=0 immediately clears every register bit to 0, independent of clk. All E/M/W outputs are therefore 0. Reset dominates flushE.
- Flush affects only ID/EX. The instructions already in M and W advance normally, so a flush creates exactly one bubble.
- Deasserting reset mid-stream: the first edge after release captures the current D inputs. Bubbles (zeros) drain through M and W on the following edges.

Decomposition:
- Shared package holds:
  - ALU-op class constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_OR=11.
  - 4-bit ALU control constants: AND, OR, ADD, SUB, SLT, MULT, DIV.
  - funct codes.
  - Packed struct types for the ID/EX, EX/MEM and MEM/WB payloads.
- One sub-module: pipe_reg. It is a WIDTH-parameterised flop with async active-low reset and an optional synchronous clear input. It is instantiated three times, with the clear tied to 0 for EX/MEM and MEM/WB.
- The ALU decode is an always_comb case inside ctrl_pipe.

Test Plan:
1. Hold reset=0 with all D inputs at 1 and toggle clk -> all E/M/W outputs remain 0. Release reset -> after 1/2/3 edges the E, M and W outputs read 1 and alucontrolE matches the decode.
2. aluopD=10 and sweep functD over 100000, 100010, 100100, 100101, 101010, 011000, 011010, 111111 -> alucontrolE one edge later is 0010, 0110, 0000, 0001, 0111, 1000, 1001, 0010.
3. Apply an lw pattern (memtoregD=1, regwriteD=1, alusrcD=1, aluopD=00) for one cycle, then zeros -> memtoregE, M and W each pulse for one cycle on successive edges; alucontrolE=0010.
4. Set flushE=1 while regwriteD=1, memwriteD=1 -> after the edge all ID/EX outputs are 0. The previous E contents still reach M, and M's contents still reach W.
5. Branch select: branchD=1, equalD=1 -> pcsrcD=1; bneD=1, equalD=0 -> 1; branchD=1, equalD=0 -> 0; all flags 0 -> 0.
6. Assert reset asynchronously between edges with a non-zero pipeline -> outputs go to 0 before the next edge.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared constants and pipeline payload types for the control path
package ctrl_pipe_pkg;

    // ALU-op class from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // 4-bit ALU control
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;

    // ID/EX payload, 17 bits, MSB first
    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic [1:0] regdst;
        logic       regwrite;
        logic [3:0] alucontrol;
        logic       jal;
        logic       lb;
        logic       multordiv;
        logic       hlwrite;
        logic [1:0] mfhl;
        logic       sb;
    } id_ex_t;

    // EX/MEM payload, 9 bits
    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       jal;
        logic       lb;
        logic       hlwrite;
        logic [1:0] mfhl;
        logic       sb;
    } ex_mem_t;

    // MEM/WB payload, 7 bits
    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic       jal;
        logic       lb;
        logic       hlwrite;
        logic [1:0] mfhl;
    } mem_wb_t;

endpackage

// File: rtl/ctrl_pipe_pipe_reg.sv
// rtl/ctrl_pipe_pipe_reg.sv - pipeline register with async active-low reset and sync clear
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over clear; clear inserts a bubble of zeros
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-path pipeline slice: ALU decode, branch select, ID/EX/MEM/WB control registers
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] functD,
    input  logic [1:0] aluopD,
    input  logic       memtoregD,
    input  logic       memwriteD,
    input  logic       alusrcD,
    input  logic       regwriteD,
    input  logic       jalD,
    input  logic       lbD,
    input  logic       sbD,
    input  logic       multordivD,
    input  logic       hlwriteD,
    input  logic [1:0] regdstD,
    input  logic [1:0] mfhlD,
    input  logic       branchD,
    input  logic       bneD,
    input  logic       equalD,
    input  logic       flushE,
    output logic       pcsrcD,
    output logic [3:0] alucontrolE,
    output logic       memtoregE,
    output logic       alusrcE,
    output logic       regwriteE,
    output logic       multordivE,
    output logic       hlwriteE,
    output logic [1:0] regdstE,
    output logic       memtoregM,
    output logic       memwriteM,
    output logic       regwriteM,
    output logic       hlwriteM,
    output logic       sbM,
    output logic       memtoregW,
    output logic       regwriteW,
    output logic       jalW,
    output logic       lbW,
    output logic       hlwriteW,
    output logic [1:0] mfhlW
);

    logic [3:0] alucontrolD;
    id_ex_t     id_ex_d;
    id_ex_t     id_ex_q;
    ex_mem_t    ex_mem_d;
    ex_mem_t    ex_mem_q;
    mem_wb_t    mem_wb_d;
    mem_wb_t    mem_wb_q;

    assign pcsrcD = (branchD & equalD) | (bneD & ~equalD);

    // ALU control decode; unknown funct falls back to ADD so the output is always defined
    always_comb begin
        alucontrolD = ALU_ADD;
        case (aluopD)
            ALUOP_ADD: alucontrolD = ALU_ADD;
            ALUOP_SUB: alucontrolD = ALU_SUB;
            ALUOP_OR:  alucontrolD = ALU_OR;
            ALUOP_FUNCT: begin
                case (functD)
                    FUNCT_ADD:  alucontrolD = ALU_ADD;
                    FUNCT_SUB:  alucontrolD = ALU_SUB;
                    FUNCT_AND:  alucontrolD = ALU_AND;
                    FUNCT_OR:   alucontrolD = ALU_OR;
                    FUNCT_SLT:  alucontrolD = ALU_SLT;
                    FUNCT_MULT: alucontrolD = ALU_MULT;
                    FUNCT_DIV:  alucontrolD = ALU_DIV;
                    FUNCT_MFHI: alucontrolD = ALU_ADD;
                    FUNCT_MFLO: alucontrolD = ALU_ADD;
                    default:    alucontrolD = ALU_ADD;
                endcase
            end
            default: alucontrolD = ALU_ADD;
        endcase
    end

    // Gather ID-stage control into the ID/EX payload
    always_comb begin
        id_ex_d            = '0;
        id_ex_d.memtoreg   = memtoregD;
        id_ex_d.memwrite   = memwriteD;
        id_ex_d.alusrc     = alusrcD;
        id_ex_d.regdst     = regdstD;
        id_ex_d.regwrite   = regwriteD;
        id_ex_d.alucontrol = alucontrolD;
        id_ex_d.jal        = jalD;
        id_ex_d.lb         = lbD;
        id_ex_d.multordiv  = multordivD;
        id_ex_d.hlwrite    = hlwriteD;
        id_ex_d.mfhl       = mfhlD;
        id_ex_d.sb         = sbD;
    end

    // Forward the fields still needed after EX
    always_comb begin
        ex_mem_d          = '0;
        ex_mem_d.memtoreg = id_ex_q.memtoreg;
        ex_mem_d.memwrite = id_ex_q.memwrite;
        ex_mem_d.regwrite = id_ex_q.regwrite;
        ex_mem_d.jal      = id_ex_q.jal;
        ex_mem_d.lb       = id_ex_q.lb;
        ex_mem_d.hlwrite  = id_ex_q.hlwrite;
        ex_mem_d.mfhl     = id_ex_q.mfhl;
        ex_mem_d.sb       = id_ex_q.sb;
    end

    // Forward the fields still needed after MEM
    always_comb begin
        mem_wb_d          = '0;
        mem_wb_d.memtoreg = ex_mem_q.memtoreg;
        mem_wb_d.regwrite = ex_mem_q.regwrite;
        mem_wb_d.jal      = ex_mem_q.jal;
        mem_wb_d.lb       = ex_mem_q.lb;
        mem_wb_d.hlwrite  = ex_mem_q.hlwrite;
        mem_wb_d.mfhl     = ex_mem_q.mfhl;
    end

    pipe_reg #(.WIDTH($bits(id_ex_t))) u_id_ex (
        .clk   (clk),
        .reset (reset),
        .clear (flushE),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    pipe_reg #(.WIDTH($bits(ex_mem_t))) u_ex_mem (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .d     (ex_mem_d),
        .q     (ex_mem_q)
    );

    pipe_reg #(.WIDTH($bits(mem_wb_t))) u_mem_wb (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .d     (mem_wb_d),
        .q     (mem_wb_q)
    );

    assign alucontrolE = id_ex_q.alucontrol;
    assign memtoregE   = id_ex_q.memtoreg;
    assign alusrcE     = id_ex_q.alusrc;
    assign regwriteE   = id_ex_q.regwrite;
    assign multordivE  = id_ex_q.multordiv;
    assign hlwriteE    = id_ex_q.hlwrite;
    assign regdstE     = id_ex_q.regdst;

    assign memtoregM   = ex_mem_q.memtoreg;
    assign memwriteM   = ex_mem_q.memwrite;
    assign regwriteM   = ex_mem_q.regwrite;
    assign hlwriteM    = ex_mem_q.hlwrite;
    assign sbM         = ex_mem_q.sb;

    assign memtoregW   = mem_wb_q.memtoreg;
    assign regwriteW   = mem_wb_q.regwrite;
    assign jalW        = mem_wb_q.jal;
    assign lbW         = mem_wb_q.lb;
    assign hlwriteW    = mem_wb_q.hlwrite;
    assign mfhlW       = mem_wb_q.mfhl;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed scoreboard bench for ctrl_pipe
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] functD;
    logic [1:0] aluopD;
    logic       memtoregD, memwriteD, alusrcD, regwriteD, jalD, lbD, sbD, multordivD, hlwriteD;
    logic [1:0] regdstD, mfhlD;
    logic       branchD, bneD, equalD, flushE;
    logic       pcsrcD;
    logic [3:0] alucontrolE;
    logic       memtoregE, alusrcE, regwriteE, multordivE, hlwriteE;
    logic [1:0] regdstE;
    logic       memtoregM, memwriteM, regwriteM, hlwriteM, sbM;
    logic       memtoregW, regwriteW, jalW, lbW, hlwriteW;
    logic [1:0] mfhlW;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic [1:0] regdst;
        logic       regwrite;
        logic [3:0] alu;
        logic       jal;
        logic       lb;
        logic       multordiv;
        logic       hlwrite;
        logic [1:0] mfhl;
        logic       sb;
    } pay_t;

    pay_t q_e[$];
    pay_t q_m[$];
    pay_t q_w[$];

    int errors = 0;
    int checks = 0;

    ctrl_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .functD      (functD),
        .aluopD      (aluopD),
        .memtoregD   (memtoregD),
        .memwriteD   (memwriteD),
        .alusrcD     (alusrcD),
        .regwriteD   (regwriteD),
        .jalD        (jalD),
        .lbD         (lbD),
        .sbD         (sbD),
        .multordivD  (multordivD),
        .hlwriteD    (hlwriteD),
        .regdstD     (regdstD),
        .mfhlD       (mfhlD),
        .branchD     (branchD),
        .bneD        (bneD),
        .equalD      (equalD),
        .flushE      (flushE),
        .pcsrcD      (pcsrcD),
        .alucontrolE (alucontrolE),
        .memtoregE   (memtoregE),
        .alusrcE     (alusrcE),
        .regwriteE   (regwriteE),
        .multordivE  (multordivE),
        .hlwriteE    (hlwriteE),
        .regdstE     (regdstE),
        .memtoregM   (memtoregM),
        .memwriteM   (memwriteM),
        .regwriteM   (regwriteM),
        .hlwriteM    (hlwriteM),
        .sbM         (sbM),
        .memtoregW   (memtoregW),
        .regwriteW   (regwriteW),
        .jalW        (jalW),
        .lbW         (lbW),
        .hlwriteW    (hlwriteW),
        .mfhlW       (mfhlW)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b011000: return 4'b1000;
            6'b011010: return 4'b1001;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic pay_t expect_d();
        pay_t p;
        p = '0;
        if (!flushE) begin
            p.memtoreg  = memtoregD;
            p.memwrite  = memwriteD;
            p.alusrc    = alusrcD;
            p.regdst    = regdstD;
            p.regwrite  = regwriteD;
            p.alu       = ref_alu(aluopD, functD);
            p.jal       = jalD;
            p.lb        = lbD;
            p.multordiv = multordivD;
            p.hlwrite   = hlwriteD;
            p.mfhl      = mfhlD;
            p.sb        = sbD;
        end
        return p;
    endfunction

    function automatic logic [31:0] exp_e(input pay_t p);
        return 32'({p.memtoreg, p.alusrc, p.regdst, p.regwrite, p.alu, p.multordiv, p.hlwrite});
    endfunction
    function automatic logic [31:0] exp_m(input pay_t p);
        return 32'({p.memtoreg, p.memwrite, p.regwrite, p.hlwrite, p.sb});
    endfunction
    function automatic logic [31:0] exp_w(input pay_t p);
        return 32'({p.memtoreg, p.regwrite, p.jal, p.lb, p.hlwrite, p.mfhl});
    endfunction

    function automatic logic [31:0] obs_e();
        return 32'({memtoregE, alusrcE, regdstE, regwriteE, alucontrolE, multordivE, hlwriteE});
    endfunction
    function automatic logic [31:0] obs_m();
        return 32'({memtoregM, memwriteM, regwriteM, hlwriteM, sbM});
    endfunction
    function automatic logic [31:0] obs_w();
        return 32'({memtoregW, regwriteW, jalW, lbW, hlwriteW, mfhlW});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_e"}, obs_e(), 32'd0);
        chk({tag, "_m"}, obs_m(), 32'd0);
        chk({tag, "_w"}, obs_w(), 32'd0);
    endtask

    // Pipeline restarts from all-zero registers after any reset
    task automatic reset_queues();
        q_e.delete();
        q_m.delete();
        q_w.delete();
        q_m.push_back('0);
        q_w.push_back('0);
    endtask

    task automatic set_all(input logic v);
        functD     = {6{v}};
        aluopD     = {2{v}};
        memtoregD  = v;
        memwriteD  = v;
        alusrcD    = v;
        regwriteD  = v;
        jalD       = v;
        lbD        = v;
        sbD        = v;
        multordivD = v;
        hlwriteD   = v;
        regdstD    = {2{v}};
        mfhlD      = {2{v}};
        branchD    = 1'b0;
        bneD       = 1'b0;
        equalD     = 1'b0;
        flushE     = 1'b0;
    endtask

    // Push the expected ID/EX payload, clock once, and score all three stages
    task automatic tick(input string tag);
        pay_t pe, pm, pw;
        q_e.push_back(expect_d());
        @(posedge clk);
        #1;
        if (q_e.size() == 0 || q_m.size() == 0 || q_w.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            pe = q_e.pop_front();
            pm = q_m.pop_front();
            pw = q_w.pop_front();
            chk({tag, "_e"}, obs_e(), exp_e(pe));
            chk({tag, "_m"}, obs_m(), exp_m(pm));
            chk({tag, "_w"}, obs_w(), exp_w(pw));
            q_m.push_back(pe);
            q_w.push_back(pm);
        end
    endtask

    logic [5:0] funct_tab [8];

    initial begin
        funct_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b101010, 6'b011000, 6'b011010, 6'b111111};

        // Reset held with all inputs high: nothing propagates
        reset = 1'b0;
        set_all(1'b1);
        #1;
        chk_all_zero("rst_init");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_all_zero("rst_hold");
        end

        // Release between edges, then all-ones walks E, M, W
        #2;
        reset = 1'b1;
        reset_queues();
        tick("rel1");
        tick("rel2");
        tick("rel3");

        // funct sweep under ALU-op class 10
        set_all(1'b0);
        aluopD = 2'b10;
        foreach (funct_tab[i]) begin
            functD = funct_tab[i];
            tick($sformatf("funct%0d", i));
        end
        functD = 6'b010000;
        tick("mfhi");
        functD = 6'b010010;
        tick("mflo");
        aluopD = 2'b01;
        tick("aluop_sub");

        // lw pulse followed by zeros
        set_all(1'b0);
        memtoregD = 1'b1;
        regwriteD = 1'b1;
        alusrcD   = 1'b1;
        aluopD    = 2'b00;
        tick("lw0");
        set_all(1'b0);
        tick("lw1");
        tick("lw2");
        tick("lw3");

        // Flush inserts one bubble; older instructions keep moving
        set_all(1'b1);
        tick("pre_fl1");
        set_all(1'b0);
        regwriteD = 1'b1;
        sbD       = 1'b1;
        tick("pre_fl2");
        regwriteD = 1'b1;
        memwriteD = 1'b1;
        flushE    = 1'b1;
        tick("flush");
        flushE = 1'b0;
        tick("post_fl1");
        tick("post_fl2");

        // Branch select is combinational
        set_all(1'b0);
        branchD = 1'b1; equalD = 1'b1; #1;
        chk("br_beq_taken", 32'(pcsrcD), 32'd1);
        branchD = 1'b0; bneD = 1'b1; equalD = 1'b0; #1;
        chk("br_bne_taken", 32'(pcsrcD), 32'd1);
        branchD = 1'b1; bneD = 1'b0; equalD = 1'b0; #1;
        chk("br_beq_not", 32'(pcsrcD), 32'd0);
        branchD = 1'b0; bneD = 1'b1; equalD = 1'b1; #1;
        chk("br_bne_not", 32'(pcsrcD), 32'd0);
        branchD = 1'b0; bneD = 1'b0; equalD = 1'b0; #1;
        chk("br_none", 32'(pcsrcD), 32'd0);

        // Async reset between edges with a full pipeline
        set_all(1'b1);
        tick("pre_ar1");
        tick("pre_ar2");
        tick("pre_ar3");
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2;
        reset = 1'b1;
        reset_queues();
        set_all(1'b0);
        aluopD = 2'b10;
        functD = 6'b011010;
        multordivD = 1'b1;
        hlwriteD = 1'b1;
        tick("after_ar1");
        set_all(1'b0);
        tick("after_ar2");
        tick("after_ar3");

        // Reset dominates flush
        set_all(1'b1);
        flushE = 1'b1;
        reset  = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("rst_over_flush");
        reset = 1'b1;
        flushE = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
